// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the multicore memory system:
//   word_t / addr_t : default data and address words
//   ramstate_t      : RAM controller status (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t     : memory arbiter FSM state (IDLE, SERVE)
//   ptr_w()         : width of a core index for a given core count
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // A single core still needs a 1-bit index.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker: returns the first requesting index found
// scanning upward from i_start with wrap-around.
//   i_req   : one request bit per core
//   i_start : scan start index (the round-robin pointer)
//   o_valid : at least one request present
//   o_idx   : selected core index
// -----------------------------------------------------------------------------
module rr_picker
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int PTR_W = ptr_w(CPUS)
) (
    input  logic [CPUS-1:0]  i_req,
    input  logic [PTR_W-1:0] i_start,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_idx
);

    // Scan from the far end back toward i_start so the nearest hit is the
    // last assignment and therefore wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            int w_c;
            w_c = (int'(i_start) + k) % CPUS;
            if (i_req[w_c]) begin
                o_valid = 1'b1;
                o_idx   = PTR_W'(w_c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one RAM port between the icache and dcache ports of CPUS cores.
// Dcache requests win over icache fetches; cores are served round-robin
// within each class from a common pointer. One grant is outstanding at a time
// and an idle cycle separates back-to-back grants.
//
// Ports:
//   CLK, RST              : clock, synchronous active-high reset
//   iREN/iaddr            : icache read request/address per core
//   iwait/iload           : icache wait (low in completion cycle) / read data
//   dREN/dWEN/daddr/dstore: dcache read/write request, address, write data
//   dwait/dload           : dcache wait / read data
//   ramREN/ramWEN/ramaddr/ramstore : RAM request (combinational from grant)
//   ramload/ramstate      : RAM read data and status
//
// Optional feature (macro MEM_ARBITER_PERF_EN):
//   stall_cnt[c] : cycles core c has a port requesting with wait high
//   grant_cnt    : completed accesses
//   Both saturate at all-ones and clear on RST.
// -----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CPUS-1:0]               iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]               iwait,
    output logic [CPUS-1:0][DATA_W-1:0]   iload,
    input  logic [CPUS-1:0]               dREN,
    input  logic [CPUS-1:0]               dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   daddr,
    input  logic [CPUS-1:0][DATA_W-1:0]   dstore,
    output logic [CPUS-1:0]               dwait,
    output logic [CPUS-1:0][DATA_W-1:0]   dload,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [ADDR_W-1:0]             ramaddr,
    output logic [DATA_W-1:0]             ramstore,
    input  logic [DATA_W-1:0]             ramload,
    input  logic [1:0]                    ramstate
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [CPUS-1:0][31:0]         stall_cnt,
    output logic [31:0]                   grant_cnt
`endif
);

    localparam int PTR_W = ptr_w(CPUS);

    arb_state_t        r_state;
    logic [PTR_W-1:0]  r_grant_core;
    logic              r_grant_is_d;
    logic [PTR_W-1:0]  r_rr_ptr;

    logic [CPUS-1:0]   w_dreq;
    logic              w_d_vld;
    logic [PTR_W-1:0]  w_d_idx;
    logic              w_i_vld;
    logic [PTR_W-1:0]  w_i_idx;
    logic              w_g_ren;
    logic              w_g_wen;
    logic              w_g_active;
    logic              w_serve;
    logic              w_done;
    logic [PTR_W-1:0]  w_rr_next;

    assign w_dreq = dREN | dWEN;

    rr_picker #(.CPUS(CPUS), .PTR_W(PTR_W)) u_pick_d (
        .i_req   (w_dreq),
        .i_start (r_rr_ptr),
        .o_valid (w_d_vld),
        .o_idx   (w_d_idx)
    );

    rr_picker #(.CPUS(CPUS), .PTR_W(PTR_W)) u_pick_i (
        .i_req   (iREN),
        .i_start (r_rr_ptr),
        .o_valid (w_i_vld),
        .o_idx   (w_i_idx)
    );

    // Granted port's live enables; an icache port never writes.
    assign w_g_ren    = r_grant_is_d ? dREN[r_grant_core] : iREN[r_grant_core];
    assign w_g_wen    = r_grant_is_d & dWEN[r_grant_core];
    assign w_g_active = w_g_ren | w_g_wen;

    // RST gates the RAM request combinationally so a reset mid-access drops
    // the enables in the very cycle it is sampled.
    assign w_serve = (r_state == SERVE) & ~RST;
    assign w_done  = w_serve & w_g_active & (ramstate_t'(ramstate) == ACCESS);

    assign w_rr_next = (r_grant_core == PTR_W'(CPUS - 1)) ? '0 : r_grant_core + 1'b1;

    // RAM request from the granted port; write wins over read.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (w_serve) begin
            ramWEN = w_g_wen;
            ramREN = w_g_ren & ~w_g_wen;
            if (r_grant_is_d) begin
                ramaddr  = daddr[r_grant_core];
                ramstore = dstore[r_grant_core];
            end else begin
                ramaddr  = iaddr[r_grant_core];
            end
        end
    end

    // Waits drop only for the granted port in its completion cycle.
    always_comb begin
        iwait = '1;
        dwait = '1;
        if (w_done) begin
            if (r_grant_is_d) dwait[r_grant_core] = 1'b0;
            else              iwait[r_grant_core] = 1'b0;
        end
    end

    // Load data is broadcast; each port qualifies it with its own wait.
    always_comb begin
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = ramload;
            dload[c] = ramload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_grant_core <= '0;
            r_grant_is_d <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_d_vld) begin
                        r_grant_core <= w_d_idx;
                        r_grant_is_d <= 1'b1;
                        r_state      <= SERVE;
                    end else if (w_i_vld) begin
                        r_grant_core <= w_i_idx;
                        r_grant_is_d <= 1'b0;
                        r_state      <= SERVE;
                    end
                end
                SERVE: begin
                    // Abort leaves the pointer alone; completion advances it.
                    if (!w_g_active) begin
                        r_state <= IDLE;
                    end else if (w_done) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    logic [CPUS-1:0][31:0] r_stall_cnt;
    logic [31:0]           r_grant_cnt;
    logic [CPUS-1:0]       w_stall;

    assign w_stall   = (iREN & iwait) | (w_dreq & dwait);
    assign stall_cnt = r_stall_cnt;
    assign grant_cnt = r_grant_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_grant_cnt <= '0;
        end else begin
            for (int c = 0; c < CPUS; c++) begin
                if (w_stall[c] && (r_stall_cnt[c] != '1))
                    r_stall_cnt[c] <= r_stall_cnt[c] + 32'd1;
            end
            if (w_done && (r_grant_cnt != '1))
                r_grant_cnt <= r_grant_cnt + 32'd1;
        end
    end
`endif

endmodule
